param_sync_fifo: RTL and testbench



---
 rtl/fifo_pkg.sv | 16 +
 rtl/param_sync_fifo_if.sv | 36 +++
 rtl/fifo_mem.sv | 33 +++
 rtl/param_sync_fifo.sv | 130 +++++++++++++
 tb/tb_param_sync_fifo.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parameterised synchronous FIFO.
//   DEF_*      : default parameter values
//   ptr_width  : read/write pointer width for a given entry count
package fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_DEPTH      = 16;
  localparam int unsigned DEF_AEMPTY_TH  = 2;
  localparam int unsigned DEF_FWFT       = 0;

  // Pointer width; DEPTH is a power of two so pointers wrap naturally.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return unsigned'($clog2(depth));
  endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Bus bundle for param_sync_fifo.
//   master : producer/consumer side (drives winc/wdata/rinc/flush)
//   slave  : FIFO side (drives data, fill level and status flags)
interface param_sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH
);

  localparam int unsigned CW = ptr_width(DEPTH) + 1;

  logic                  flush;
  logic                  winc;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wfull;
  logic                  walmost_full;
  logic                  rinc;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rempty;
  logic                  ralmost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, winc, wdata, rinc,
    input  wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, winc, wdata, rinc,
    output wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: DATA_WIDTH x DEPTH register array, one synchronous write
// port and one asynchronous read port. Contents are never reset.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from raddr_i)
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        we_i,
  input  logic [ptr_width(DEPTH)-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]       wdata_i,
  input  logic [ptr_width(DEPTH)-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]       rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with fill count, almost-full/empty flags, sticky
// overflow/underflow, synchronous flush and selectable read mode
// (FWFT=0 registered read, FWFT=1 first-word-fall-through).
//   clk, rst       : clock, asynchronous active-high reset
//   flush          : synchronous clear of pointers, count and sticky flags
//   winc, wdata    : write request and data; wfull / walmost_full status
//   rinc, rdata    : read request and data; rempty / ralmost_empty status
//   count          : fill level 0..DEPTH
//   overflow       : sticky, write attempted while full
//   underflow      : sticky, read attempted while empty
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned AFULL_TH   = DEPTH - 2,
  parameter int unsigned AEMPTY_TH  = DEF_AEMPTY_TH,
  parameter int unsigned FWFT       = DEF_FWFT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    winc,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic                    wfull,
  output logic                    walmost_full,
  input  logic                    rinc,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rempty,
  output logic                    ralmost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_en_c, rd_en_c;
  logic [DATA_WIDTH-1:0] mem_rdata_c;

  // Status flags depend only on the registered count.
  assign wfull         = (count_q == CW'(DEPTH));
  assign rempty        = (count_q == '0);
  assign walmost_full  = (count_q >= CW'(AFULL_TH));
  assign ralmost_empty = (count_q <= CW'(AEMPTY_TH));
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

  // Next-state for pointers, count and sticky flags; flush wins over traffic.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wr_en_c     = winc && !wfull && !flush;
    rd_en_c     = rinc && !rempty && !flush;

    if (flush) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_en_c) wptr_d = wptr_q + PW'(1);
      if (rd_en_c) rptr_d = rptr_q + PW'(1);
      case ({wr_en_c, rd_en_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (winc && wfull)  overflow_d  = 1'b1;
      if (rinc && rempty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en_c),
    .waddr_i (wptr_q),
    .wdata_i (wdata),
    .raddr_i (rptr_q),
    .rdata_o (mem_rdata_c)
  );

  // Read path: head entry straight from memory, or captured on each pop.
  if (FWFT != 0) begin : g_fwft
    assign rdata = mem_rdata_c;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q <= '0;
      end else if (rd_en_c) begin
        rdata_q <= mem_rdata_c;
      end
    end

    assign rdata = rdata_q;
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
module tb_param_sync_fifo;
  import fifo_pkg::*;

  localparam int unsigned DW   = 8;
  localparam int unsigned DEP  = 8;
  localparam int unsigned AFTH = 6;
  localparam int unsigned AETH = 2;

  logic clk = 1'b0;
  logic rst;
  logic tb_flush, tb_winc, tb_rinc;
  logic [DW-1:0] tb_wdata;

  always #5 clk = ~clk;

  param_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEP)) if0 ();
  param_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEP)) if1 ();

  assign if0.flush = tb_flush;
  assign if0.winc  = tb_winc;
  assign if0.wdata = tb_wdata;
  assign if0.rinc  = tb_rinc;
  assign if1.flush = tb_flush;
  assign if1.winc  = tb_winc;
  assign if1.wdata = tb_wdata;
  assign if1.rinc  = tb_rinc;

  param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEP), .AFULL_TH(AFTH), .AEMPTY_TH(AETH), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .flush(if0.flush), .winc(if0.winc), .wdata(if0.wdata),
    .wfull(if0.wfull), .walmost_full(if0.walmost_full), .rinc(if0.rinc), .rdata(if0.rdata),
    .rempty(if0.rempty), .ralmost_empty(if0.ralmost_empty), .count(if0.count),
    .overflow(if0.overflow), .underflow(if0.underflow)
  );

  param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEP), .AFULL_TH(AFTH), .AEMPTY_TH(AETH), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .flush(if1.flush), .winc(if1.winc), .wdata(if1.wdata),
    .wfull(if1.wfull), .walmost_full(if1.walmost_full), .rinc(if1.rinc), .rdata(if1.rdata),
    .rempty(if1.rempty), .ralmost_empty(if1.ralmost_empty), .count(if1.count),
    .overflow(if1.overflow), .underflow(if1.underflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a plain queue plus sticky flags and the last popped word.
  logic [DW-1:0] m_q[$];
  logic          m_ovf, m_unf;
  logic [DW-1:0] m_rd0;

  typedef struct {
    logic          flush, winc, rinc;
    logic [DW-1:0] wdata;
    int            cnt;
    logic          full, empty, afull, aempty, ovf, unf;
    logic [DW-1:0] rd0;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rd0 = '0;
  endtask

  task automatic model_step(input logic fl, input logic wi, input logic [DW-1:0] wd, input logic ri);
    bit full, empty;
    full  = (m_q.size() == DEP);
    empty = (m_q.size() == 0);
    if (fl) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (wi && full)  m_ovf = 1'b1;
      if (ri && empty) m_unf = 1'b1;
      if (ri && !empty) m_rd0 = m_q.pop_front();
      if (wi && !full) m_q.push_back(wd);
    end
  endtask

  task automatic check_all(input string tag);
    int c;
    c = m_q.size();
    chk({tag, ".count0"}, 32'(if0.count), 32'(c));
    chk({tag, ".count1"}, 32'(if1.count), 32'(c));
    chk({tag, ".wfull"},  32'(if0.wfull),  32'(c == DEP));
    chk({tag, ".rempty"}, 32'(if0.rempty), 32'(c == 0));
    chk({tag, ".afull"},  32'(if0.walmost_full),  32'(c >= AFTH));
    chk({tag, ".aempty"}, 32'(if0.ralmost_empty), 32'(c <= AETH));
    chk({tag, ".ovf"},    32'(if0.overflow),  32'(m_ovf));
    chk({tag, ".unf"},    32'(if0.underflow), 32'(m_unf));
    chk({tag, ".rempty1"}, 32'(if1.rempty), 32'(c == 0));
    chk({tag, ".ovf1"},    32'(if1.overflow),  32'(m_ovf));
    chk({tag, ".unf1"},    32'(if1.underflow), 32'(m_unf));
    chk({tag, ".rdata0"}, 32'(if0.rdata), 32'(m_rd0));
    if (c != 0) chk({tag, ".rdata1"}, 32'(if1.rdata), 32'(m_q[0]));
  endtask

  // Drive one cycle's inputs, take the edge, update model, compare on negedge.
  task automatic cycle(input logic fl, input logic wi, input logic [DW-1:0] wd, input logic ri,
                       input string tag);
    tb_flush = fl; tb_winc = wi; tb_wdata = wd; tb_rinc = ri;
    @(posedge clk);
    model_step(fl, wi, wd, ri);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle();
    tb_flush = 1'b0; tb_winc = 1'b0; tb_rinc = 1'b0; tb_wdata = '0;
  endtask

  function automatic vec_t mk(input logic fl, input logic wi, input logic [DW-1:0] wd,
                              input logic ri, input int cnt, input logic ovf, input logic unf,
                              input logic [DW-1:0] rd0);
    vec_t v;
    v.flush = fl; v.winc = wi; v.wdata = wd; v.rinc = ri;
    v.cnt = cnt;
    v.full = (cnt == DEP); v.empty = (cnt == 0);
    v.afull = (cnt >= AFTH); v.aempty = (cnt <= AETH);
    v.ovf = ovf; v.unf = unf; v.rd0 = rd0;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    idle();
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.rempty", 32'(if0.rempty), 32'd1);
    chk("reset.count",  32'(if0.count),  32'd0);
    chk("reset.rdata0", 32'(if0.rdata),  32'd0);
    rst = 1'b0;
    check_all("reset");

    // Fill 0x01..0x08, overflow on 9th write, drain, then underflow.
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(0, 1, DW'(i), 0, i, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 8'h99, 0, 8, 1, 0, 8'h00));
    for (int k = 1; k <= 8; k++) vecs.push_back(mk(0, 0, 8'h00, 1, 8 - k, 1, 0, DW'(k)));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 1, 8'h08));

    foreach (vecs[i]) begin
      cycle(vecs[i].flush, vecs[i].winc, vecs[i].wdata, vecs[i].rinc, "vec");
      chk($sformatf("vec%0d.count", i),  32'(if0.count),         32'(vecs[i].cnt));
      chk($sformatf("vec%0d.full", i),   32'(if0.wfull),         32'(vecs[i].full));
      chk($sformatf("vec%0d.empty", i),  32'(if0.rempty),        32'(vecs[i].empty));
      chk($sformatf("vec%0d.afull", i),  32'(if0.walmost_full),  32'(vecs[i].afull));
      chk($sformatf("vec%0d.aempty", i), 32'(if0.ralmost_empty), 32'(vecs[i].aempty));
      chk($sformatf("vec%0d.ovf", i),    32'(if0.overflow),      32'(vecs[i].ovf));
      chk($sformatf("vec%0d.unf", i),    32'(if0.underflow),     32'(vecs[i].unf));
      chk($sformatf("vec%0d.rdata0", i), 32'(if0.rdata),         32'(vecs[i].rd0));
    end

    // Flush clears sticky flags; then FWFT write/read of 0xA5.
    cycle(1, 0, 8'h00, 0, "flush0");
    cycle(0, 1, 8'hA5, 0, "fwft_w");
    chk("fwft.rdata1", 32'(if1.rdata), 32'hA5);
    chk("fwft.rempty1", 32'(if1.rempty), 32'd0);
    cycle(0, 0, 8'h00, 1, "fwft_r");
    chk("fwft.rempty_after", 32'(if1.rempty), 32'd1);
    chk("fwft.rdata0_pop", 32'(if0.rdata), 32'hA5);

    // Count 4 with simultaneous write+read across pointer wrap-around.
    for (int i = 0; i < 4; i++) cycle(0, 1, DW'(8'h10 + i), 0, "pre4");
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, DW'(8'h20 + i), 1, "wr_rd");
      chk("wr_rd.count", 32'(if0.count), 32'd4);
    end
    chk("wr_rd.last", 32'(if0.rdata), 32'h2F);

    // Both sticky flags set at full, then flush + winc together.
    cycle(1, 0, 8'h00, 0, "flush1");
    cycle(0, 0, 8'h00, 1, "unf_set");
    for (int i = 0; i < 8; i++) cycle(0, 1, DW'(8'h40 + i), 0, "fill");
    cycle(0, 1, 8'hEE, 0, "ovf_set");
    chk("both.ovf", 32'(if0.overflow), 32'd1);
    chk("both.unf", 32'(if0.underflow), 32'd1);
    cycle(1, 1, 8'h77, 0, "flush_w");
    chk("flushw.count", 32'(if0.count), 32'd0);
    chk("flushw.rempty", 32'(if0.rempty), 32'd1);
    chk("flushw.ovf", 32'(if0.overflow), 32'd0);
    chk("flushw.unf", 32'(if0.underflow), 32'd0);

    // Asynchronous reset mid-burst at count 5.
    for (int i = 0; i < 5; i++) cycle(0, 1, DW'(8'h50 + i), 0, "burst");
    tb_winc = 1'b1; tb_wdata = 8'h55;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst.count",  32'(if0.count),         32'd0);
    chk("arst.rempty", 32'(if0.rempty),        32'd1);
    chk("arst.wfull",  32'(if0.wfull),         32'd0);
    chk("arst.aempty", 32'(if0.ralmost_empty), 32'd1);
    chk("arst.afull",  32'(if0.walmost_full),  32'd0);
    chk("arst.rdata0", 32'(if0.rdata),         32'd0);
    idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all("arst");
    cycle(0, 1, 8'h3C, 0, "post_w1");
    chk("post.rdata1", 32'(if1.rdata), 32'h3C);
    cycle(0, 1, 8'h4D, 1, "post_wr");
    chk("post.rdata0", 32'(if0.rdata), 32'h3C);

    // Randomised traffic with phases biased towards filling or draining.
    for (int i = 0; i < 3000; i++) begin
      int wp, rp;
      wp = ((i / 200) % 2 == 0) ? 70 : 30;
      rp = 100 - wp;
      d = DW'($urandom);
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < wp), d,
            ($urandom_range(0, 99) < rp), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
